// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption core: one full round per clock.
// The caller supplies the expanded key schedule; ciphertext is held until the handshake.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TBL[a];
endmodule

// One MixColumns column; col[31:24] is row 0.
module aes_mix_col (
  input  logic [31:0] col,
  output logic [31:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign y[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  assign y[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
  assign y[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
  assign y[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

module aes_round_engine #(
  parameter int LATCH_KEYS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  plaintext,
  input  logic [0:1407] word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  ciphertext,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state;
  logic [3:0]   round;
  logic [127:0] st;            // byte i of the AES state lives in st[127-8i -: 8]
  logic [0:1407] key_src;
  logic [127:0] rk [16];
  logic [127:0] sub, shf, mix, nxt;

  assign in_ready = (state == IDLE);
  assign busy     = (state == ROUND);

  generate
    if (LATCH_KEYS != 0) begin : g_latch
      logic [0:1407] key_q;
      always_ff @(posedge clk) begin
        if (!rst_n)                    key_q <= '0;
        else if (in_valid && in_ready) key_q <= word;
      end
      assign key_src = key_q;
    end else begin : g_live
      assign key_src = word;
    end
  endgenerate

  // Round-key table padded to 16 entries so the 4-bit counter indexes it directly.
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r < 11) begin : g_used
      assign rk[r] = key_src[128*r +: 128];
    end else begin : g_pad
      assign rk[r] = '0;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sub[127-8*i -: 8]));
  end

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shf[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
    end
    aes_mix_col u_mix (.col(shf[127-32*c -: 32]), .y(mix[127-32*c -: 32]));
  end

  assign nxt = ((round == 4'd10) ? shf : mix) ^ rk[round];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= '0;
      st         <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st    <= plaintext ^ word[0 +: 128];
          round <= 4'd1;
          state <= ROUND;
        end
        ROUND: begin
          st <= nxt;
          if (round == 4'd10) begin
            ciphertext <= nxt;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboarded bench for aes_round_engine using the FIPS-197 known-answer vectors.
module tb_aes_round_engine;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, busy;
  logic [0:127]  plaintext = '0;
  logic [0:127]  ciphertext;
  logic [0:1407] word = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];
  int acc_log [$];
  logic [127:0] mon_exp;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  aes_round_engine #(.LATCH_KEYS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .word(word), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // AES-128 KeyExpansion, used only to build the stimulus bus.
  function automatic logic [0:1407] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_log.push_back(cyc);
    cyc++;
  end

  // Monitor: every completed output handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", ciphertext);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ciphertext", ciphertext, mon_exp);
      end
    end
  end

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] expct, input bit corrupt, input int hold);
    int   n;
    logic stable;
    exp_q.push_back(expct);
    out_ready = (hold == 0);
    plaintext = pt;
    word      = expand(key);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", {busy, in_ready}, 2'b10);
    in_valid = 1'b0;
    if (corrupt) begin
      plaintext = '1;
      word      = '1;
    end
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 10);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || ciphertext !== expct) stable = 1'b0;
      end
      chk("backpressure_hold", stable, 1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after_handshake", {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, busy, in_ready}, 3'b001);
    chk("reset_ciphertext", ciphertext, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", in_ready, 1);

    // out_ready high with nothing pending must not produce anything
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_ready_noop", {out_valid, in_ready}, 2'b01);

    run_block(PB, KB, CB, 1'b1, 0);
    run_block(PC, KC, CC, 1'b0, 0);
    run_block(PB, KB, CB, 1'b0, 20);

    // abort in round 5
    plaintext = PC;
    word      = expand(KC);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_round_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_flags", {out_valid, busy, in_ready}, 3'b001);
    chk("rst_mid_ciphertext", ciphertext, '0);
    rst_n = 1'b1;
    run_block(PB, KB, CB, 1'b0, 0);

    // back-to-back with in_valid held high
    exp_q.push_back(CB);
    exp_q.push_back(CC);
    base      = acc_log.size();
    out_ready = 1'b1;
    plaintext = PB;
    word      = expand(KB);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    plaintext = PC;
    word      = expand(KC);
    n = 0;
    while (acc_log.size() < base + 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc_log.size() >= base + 2) chk("b2b_period", acc_log[base+1] - acc_log[base], 12);
    else                            chk("b2b_second_accept", acc_log.size(), base + 2);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
